// File: rtl/lb2x2_pkg.sv
// Shared types and constants for the 2x2 line-buffer sequencer (linebuffer_2x2_ctrl).
package lb2x2_pkg;

  localparam int unsigned LB_HW      = 9;
  localparam logic [2:0]  LB_SEL_MAX = 3'd5;
  localparam int unsigned LB_W_TAB [6] = '{8, 16, 32, 64, 128, 256};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } lb_state_t;

endpackage

// File: rtl/lb2x2_valid_pipe.sv
// Fixed-depth delay line carrying {valid, row, col, last} from pixel accept
// to the point where the matching window leaves the line-buffer bank.
module lb2x2_valid_pipe
  import lb2x2_pkg::*;
#(
  parameter int unsigned LAT = 1,
  parameter int unsigned HW  = LB_HW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_valid,
  input  logic [HW-1:0] i_row,
  input  logic [HW-1:0] i_col,
  input  logic          i_last,
  output logic          o_valid,
  output logic [HW-1:0] o_row,
  output logic [HW-1:0] o_col,
  output logic          o_last
);

  logic          r_valid [LAT];
  logic [HW-1:0] r_row   [LAT];
  logic [HW-1:0] r_col   [LAT];
  logic          r_last  [LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        r_valid[i] <= 1'b0;
        r_row[i]   <= '0;
        r_col[i]   <= '0;
        r_last[i]  <= 1'b0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_row[0]   <= i_row;
      r_col[0]   <= i_col;
      r_last[0]  <= i_last;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_row[i]   <= r_row[i-1];
        r_col[i]   <= r_col[i-1];
        r_last[i]  <= r_last[i-1];
      end
    end
  end

  assign o_valid = r_valid[LAT-1];
  assign o_row   = r_row[LAT-1];
  assign o_col   = r_col[LAT-1];
  assign o_last  = r_last[LAT-1];

endmodule

// File: rtl/linebuffer_2x2_ctrl.sv
// Sequencer for the 8-lane 2x2 line-buffer bank feeding max-pool.
// Optional overlapping-window mode is enabled by defining LB2X2_STRIDE1_EN.
module linebuffer_2x2_ctrl
  import lb2x2_pkg::*;
#(
  parameter int unsigned W0     = LB_W_TAB[0],
  parameter int unsigned W1     = LB_W_TAB[1],
  parameter int unsigned W2     = LB_W_TAB[2],
  parameter int unsigned W3     = LB_W_TAB[3],
  parameter int unsigned W4     = LB_W_TAB[4],
  parameter int unsigned W5     = LB_W_TAB[5],
  parameter int unsigned LB_LAT = 1,
  parameter int unsigned HW     = LB_HW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cfg_start,
  input  logic [2:0]    cfg_sel,
  input  logic [HW-1:0] cfg_height,
`ifdef LB2X2_STRIDE1_EN
  input  logic          cfg_stride1,
`endif
  output logic          cfg_busy,
  output logic          cfg_err,
  output logic          done,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [2:0]    lb_sel,
  output logic          lb_shift,
  output logic          win_valid,
  output logic [HW-1:0] win_row,
  output logic [HW-1:0] win_col,
  output logic          win_last
);

  function automatic logic [HW-1:0] width_m1(input logic [2:0] sel);
    case (sel)
      3'd0:    width_m1 = HW'(W0 - 1);
      3'd1:    width_m1 = HW'(W1 - 1);
      3'd2:    width_m1 = HW'(W2 - 1);
      3'd3:    width_m1 = HW'(W3 - 1);
      3'd4:    width_m1 = HW'(W4 - 1);
      default: width_m1 = HW'(W5 - 1);
    endcase
  endfunction

  lb_state_t     r_state, w_state_nxt;
  logic [HW-1:0] r_wm1, r_hm1, r_row, r_col;
  logic [2:0]    r_sel;
  logic          r_err, r_stride1;

  logic          w_stride1_in, w_cfg_ok, w_idle, w_start, w_acc, w_col_end, w_final;
  logic          w_win;
  logic [HW-1:0] w_win_row, w_win_col;
  logic          w_pipe_last;

`ifdef LB2X2_STRIDE1_EN
  assign w_stride1_in = cfg_stride1;
`else
  assign w_stride1_in = 1'b0;
`endif

  assign w_cfg_ok  = (cfg_sel <= LB_SEL_MAX) && (cfg_height >= HW'(2)) &&
                     (!cfg_height[0] || w_stride1_in);
  assign w_idle    = (r_state == ST_IDLE);
  assign w_start   = w_idle && cfg_start && w_cfg_ok;
  assign w_acc     = (r_state == ST_RUN) && s_valid;
  assign w_col_end = (r_col == r_wm1);
  assign w_final   = w_acc && w_col_end && (r_row == r_hm1);

  // Stride-2 windows close on (odd row, odd col); stride-1 on every pixel past the first row/col.
  assign w_win     = w_acc && (r_stride1 ? ((r_row != '0) && (r_col != '0))
                                         : (r_row[0] && r_col[0]));
  assign w_win_row = r_stride1 ? (r_row - HW'(1)) : {1'b0, r_row[HW-1:1]};
  assign w_win_col = r_stride1 ? (r_col - HW'(1)) : {1'b0, r_col[HW-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start)     w_state_nxt = ST_RUN;
      ST_RUN:   if (w_final)     w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_pipe_last) w_state_nxt = ST_DONE;
      ST_DONE:                   w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_wm1     <= '0;
      r_hm1     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_sel     <= '0;
      r_err     <= 1'b0;
      r_stride1 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_idle && cfg_start && !w_cfg_ok;
      if (w_start) begin
        r_wm1     <= width_m1(cfg_sel);
        r_hm1     <= cfg_height - HW'(1);
        r_sel     <= cfg_sel;
        r_stride1 <= w_stride1_in;
        r_row     <= '0;
        r_col     <= '0;
      end else if (w_acc) begin
        if (w_col_end) begin
          r_col <= '0;
          r_row <= r_row + HW'(1);
        end else begin
          r_col <= r_col + HW'(1);
        end
      end
    end
  end

  lb2x2_valid_pipe #(
    .LAT (LB_LAT),
    .HW  (HW)
  ) u_pipe (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (w_win),
    .i_row   (w_win_row),
    .i_col   (w_win_col),
    .i_last  (w_final),
    .o_valid (win_valid),
    .o_row   (win_row),
    .o_col   (win_col),
    .o_last  (w_pipe_last)
  );

  assign win_last = w_pipe_last;
  assign cfg_busy = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done     = (r_state == ST_DONE);
  assign s_ready  = (r_state == ST_RUN);
  assign lb_shift = s_valid && s_ready;
  assign cfg_err  = r_err;
  assign lb_sel   = r_sel;

endmodule
